// File: rtl/assoc_cache_controller.sv
// rtl/assoc_cache_controller.sv - control FSM for an N-way set-associative read-only cache
module assoc_cache_controller #(
    parameter int TAG_WIDTH   = 3,
    parameter int INDEX_WIDTH = 5,
    parameter int BLOCK_WIDTH = 2,
    parameter int WAYS        = 2,
    localparam int WAY_WIDTH  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int SETS       = 2 ** INDEX_WIDTH
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_rd,
    input  logic [TAG_WIDTH-1:0]   i_tag,
    input  logic [INDEX_WIDTH-1:0] i_index,
    input  logic [BLOCK_WIDTH-1:0] i_block,
    input  logic [WAYS-1:0]        i_hit,
    input  logic                   i_flush,
    input  logic                   i_mem_ack,
    output logic                   o_mem_rd,
    output logic [TAG_WIDTH-1:0]   o_tag,
    output logic [INDEX_WIDTH-1:0] o_index,
    output logic [BLOCK_WIDTH-1:0] o_block,
    output logic [WAY_WIDTH-1:0]   o_way,
    output logic                   o_wr,
    output logic                   o_cl,
    output logic                   o_hit,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [INDEX_WIDTH-1:0] count_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [BLOCK_WIDTH-1:0] blk_q;
    logic [WAY_WIDTH-1:0]   victim_q;
    logic [WAY_WIDTH-1:0]   victim_next;
    logic [WAY_WIDTH-1:0]   hit_way;
    logic                   any_hit;
    logic                   last_word;
    logic [WAY_WIDTH-1:0]   rr [SETS];

    assign any_hit   = |i_hit;
    assign last_word = (blk_q == {BLOCK_WIDTH{1'b1}});

    // Priority encode the hit vector: lowest set way wins if the tag array reports several
    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (i_hit[w]) begin
                hit_way = WAY_WIDTH'(w);
            end
        end
    end

    // Round-robin successor of the current victim; a single way stays pinned at 0
    always_comb begin
        victim_next = '0;
        if (WAYS > 1) begin
            victim_next = victim_q + WAY_WIDTH'(1);
        end
    end

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and all combinational outputs
    always_comb begin
        state_d  = state_q;
        o_tag    = i_tag;
        o_index  = i_index;
        o_block  = i_block;
        o_way    = '0;
        o_wr     = 1'b0;
        o_cl     = 1'b0;
        o_mem_rd = 1'b0;
        o_hit    = 1'b0;
        o_busy   = 1'b1;
        case (state_q)
            ST_INIT: begin
                o_cl    = 1'b1;
                o_index = count_q;
                if (count_q == {INDEX_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                o_busy = 1'b0;
                o_hit  = any_hit;
                o_way  = hit_way;
                if (i_flush) begin
                    state_d = ST_INIT;
                end else if (i_rd && !any_hit) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                o_mem_rd = 1'b1;
                o_tag    = tag_q;
                o_index  = index_q;
                o_block  = blk_q;
                o_way    = victim_q;
                o_wr     = i_mem_ack;
                if (i_mem_ack && last_word) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Set-clear counter; restarts from zero on reset or an accepted flush
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q <= '0;
        end else if (state_q == ST_INIT) begin
            count_q <= count_q + INDEX_WIDTH'(1);
        end else if (state_q == ST_IDLE && i_flush) begin
            count_q <= '0;
        end
    end

    // Miss address latches, refill word counter and per-set round-robin pointers
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            case (state_q)
                ST_INIT: begin
                    rr[count_q] <= '0;
                end
                ST_IDLE: begin
                    if (!i_flush && i_rd && !any_hit) begin
                        tag_q    <= i_tag;
                        index_q  <= i_index;
                        blk_q    <= '0;
                        victim_q <= rr[i_index];
                    end
                end
                ST_FILL: begin
                    if (i_mem_ack) begin
                        blk_q <= blk_q + BLOCK_WIDTH'(1);
                        if (last_word) begin
                            rr[index_q] <= victim_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_cache_controller.sv
// tb/tb_assoc_cache_controller.sv - directed self-checking bench for assoc_cache_controller
module tb_assoc_cache_controller;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rd = 1'b0;
    logic [2:0] i_tag = '0;
    logic [4:0] i_index = '0;
    logic [1:0] i_block = '0;
    logic [1:0] i_hit = '0;
    logic       i_flush = 1'b0;
    logic       i_mem_ack = 1'b0;
    logic       o_mem_rd;
    logic [2:0] o_tag;
    logic [4:0] o_index;
    logic [1:0] o_block;
    logic [0:0] o_way;
    logic       o_wr;
    logic       o_cl;
    logic       o_hit;
    logic       o_busy;

    int errors = 0;
    int checks = 0;

    assoc_cache_controller dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_rd     (i_rd),
        .i_tag    (i_tag),
        .i_index  (i_index),
        .i_block  (i_block),
        .i_hit    (i_hit),
        .i_flush  (i_flush),
        .i_mem_ack(i_mem_ack),
        .o_mem_rd (o_mem_rd),
        .o_tag    (o_tag),
        .o_index  (o_index),
        .o_block  (o_block),
        .o_way    (o_way),
        .o_wr     (o_wr),
        .o_cl     (o_cl),
        .o_hit    (o_hit),
        .o_busy   (o_busy)
    );

    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge i_clock);
            checks++;
            if (o_cl !== 1'b1 || o_index !== 5'(k) || o_busy !== 1'b1 || o_wr !== 1'b0 ||
                o_mem_rd !== 1'b0 || o_hit !== 1'b0 || o_way !== 1'b0) begin
                $display("FAIL init_cycle%0d got cl=%b idx=%0d busy=%b wr=%b rd=%b hit=%b way=%0d exp cl=1 idx=%0d busy=1 others=0",
                         k, o_cl, o_index, o_busy, o_wr, o_mem_rd, o_hit, o_way, k);
                errors++;
            end
            tick();
        end
        @(negedge i_clock);
        checks++;
        if (o_busy !== 1'b0 || o_cl !== 1'b0) begin
            $display("FAIL init_done got busy=%b cl=%b exp busy=0 cl=0", o_busy, o_cl);
            errors++;
        end
    endtask

    // One miss with ack held high; checks the refill way and word order
    task automatic test_miss(input logic [4:0] idx, input logic [0:0] exp_way);
        i_rd = 1'b1; i_tag = 3'd5; i_index = idx; i_block = 2'd2; i_hit = 2'b00; i_mem_ack = 1'b1;
        @(negedge i_clock);
        checks++;
        if (o_hit !== 1'b0 || o_busy !== 1'b0) begin
            $display("FAIL miss_idle got hit=%b busy=%b exp 0 0", o_hit, o_busy);
            errors++;
        end
        tick();
        i_rd = 1'b0; i_tag = 3'd1; i_index = 5'd20;
        for (int b = 0; b < 4; b++) begin
            @(negedge i_clock);
            checks++;
            if (o_mem_rd !== 1'b1 || o_wr !== 1'b1 || o_way !== exp_way || o_block !== 2'(b) ||
                o_tag !== 3'd5 || o_index !== idx || o_busy !== 1'b1) begin
                $display("FAIL miss_fill_w%0d got rd=%b wr=%b way=%0d blk=%0d tag=%0d idx=%0d busy=%b exp 1 1 way=%0d blk=%0d tag=5 idx=%0d busy=1",
                         b, o_mem_rd, o_wr, o_way, o_block, o_tag, o_index, o_busy, exp_way, b, idx);
                errors++;
            end
            tick();
        end
        i_mem_ack = 1'b0;
        @(negedge i_clock);
        checks++;
        if (o_busy !== 1'b0 || o_mem_rd !== 1'b0 || o_wr !== 1'b0) begin
            $display("FAIL miss_back_idle got busy=%b rd=%b wr=%b exp 0 0 0", o_busy, o_mem_rd, o_wr);
            errors++;
        end
        tick();
    endtask

    task automatic test_stall();
        logic [6:0] pat;
        int         blk;
        int         wr_cnt;
        pat = 7'b1011001;
        blk = 0;
        wr_cnt = 0;
        i_rd = 1'b1; i_tag = 3'd6; i_index = 5'd7; i_hit = 2'b00;
        tick();
        i_rd = 1'b0; i_tag = 3'd0; i_index = 5'd0;
        for (int c = 0; c < 7; c++) begin
            i_mem_ack = pat[c];
            @(negedge i_clock);
            checks++;
            if (o_wr !== pat[c] || o_block !== 2'(blk) || o_mem_rd !== 1'b1 ||
                o_tag !== 3'd6 || o_index !== 5'd7 || o_way !== 1'b0) begin
                $display("FAIL stall_c%0d got wr=%b blk=%0d rd=%b tag=%0d idx=%0d way=%0d exp wr=%b blk=%0d rd=1 tag=6 idx=7 way=0",
                         c, o_wr, o_block, o_mem_rd, o_tag, o_index, o_way, pat[c], blk);
                errors++;
            end
            if (o_wr === 1'b1) wr_cnt++;
            if (pat[c]) blk++;
            tick();
        end
        i_mem_ack = 1'b0;
        @(negedge i_clock);
        checks++;
        if (wr_cnt != 4 || o_busy !== 1'b0) begin
            $display("FAIL stall_end got wr_pulses=%0d busy=%b exp 4 0", wr_cnt, o_busy);
            errors++;
        end
        tick();
    endtask

    task automatic test_hit();
        i_rd = 1'b1; i_tag = 3'd5; i_index = 5'd3; i_hit = 2'b10;
        @(negedge i_clock);
        checks++;
        if (o_hit !== 1'b1 || o_way !== 1'b1 || o_busy !== 1'b0) begin
            $display("FAIL hit_10 got hit=%b way=%0d busy=%b exp 1 1 0", o_hit, o_way, o_busy);
            errors++;
        end
        tick();
        i_hit = 2'b11;
        @(negedge i_clock);
        checks++;
        if (o_hit !== 1'b1 || o_way !== 1'b0 || o_busy !== 1'b0 || o_mem_rd !== 1'b0) begin
            $display("FAIL hit_11 got hit=%b way=%0d busy=%b rd=%b exp 1 0 0 0", o_hit, o_way, o_busy, o_mem_rd);
            errors++;
        end
        tick();
        i_rd = 1'b0; i_hit = 2'b00;
        @(negedge i_clock);
        checks++;
        if (o_busy !== 1'b0 || o_hit !== 1'b0) begin
            $display("FAIL hit_stays_idle got busy=%b hit=%b exp 0 0", o_busy, o_hit);
            errors++;
        end
        tick();
    endtask

    task automatic test_flush();
        i_flush = 1'b1; i_rd = 1'b1; i_index = 5'd3; i_hit = 2'b00;
        tick();
        i_flush = 1'b0; i_rd = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge i_clock);
            checks++;
            if (o_cl !== 1'b1 || o_index !== 5'(k) || o_mem_rd !== 1'b0 || o_busy !== 1'b1) begin
                $display("FAIL flush_init%0d got cl=%b idx=%0d rd=%b busy=%b exp 1 %0d 0 1",
                         k, o_cl, o_index, o_mem_rd, o_busy, k);
                errors++;
            end
            tick();
        end
        test_miss(5'd3, 1'b0);
    endtask

    task automatic test_reset_mid_fill();
        int n;
        i_rd = 1'b1; i_tag = 3'd2; i_index = 5'd9; i_hit = 2'b00; i_mem_ack = 1'b1;
        tick();
        i_rd = 1'b0;
        tick();
        i_reset = 1'b1;
        @(negedge i_clock);
        checks++;
        if (o_mem_rd !== 1'b1 || o_block !== 2'd1) begin
            $display("FAIL rst_fill_c2 got rd=%b blk=%0d exp 1 1", o_mem_rd, o_block);
            errors++;
        end
        tick();
        i_reset = 1'b0; i_mem_ack = 1'b0;
        @(negedge i_clock);
        checks++;
        if (o_cl !== 1'b1 || o_index !== 5'd0 || o_mem_rd !== 1'b0 || o_wr !== 1'b0 || o_busy !== 1'b1) begin
            $display("FAIL rst_fill_init got cl=%b idx=%0d rd=%b wr=%b busy=%b exp 1 0 0 0 1",
                     o_cl, o_index, o_mem_rd, o_wr, o_busy);
            errors++;
        end
        n = 0;
        while (o_busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 32) begin
            $display("FAIL rst_fill_init_len got %0d exp 32", n);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        tick();
        test_miss(5'd3, 1'b0);
        test_miss(5'd3, 1'b1);
        test_miss(5'd3, 1'b0);
        test_miss(5'd3, 1'b1);
        test_stall();
        test_hit();
        test_flush();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/assoc_cache_controller.md
# assoc_cache_controller

Control FSM for an N-way set-associative, read-only (instruction-side) cache. It sits between the core fetch port, the per-way tag/valid/data arrays and an external memory port with an ack handshake. It clears all sets after reset or on a flush request and answers hits combinationally. On a miss it refills a full block word by word into a victim way chosen per set by round-robin. This block generalises the single-way controller with WAYS ways, victim selection, a stall-tolerant memory handshake and a runtime flush.

## Interface
Parameters:
- TAG_WIDTH, 3, tag width in bits
- INDEX_WIDTH, 5, set index width; SETS = 2**INDEX_WIDTH
- BLOCK_WIDTH, 2, word-in-block offset width; BLOCKS = 2**BLOCK_WIDTH
- WAYS, 2, associativity; power of two, 1..8; WAY_WIDTH = max(1, clog2(WAYS))

Ports:
- i_clock  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_rd  in  1  fetch request
- i_tag / i_index / i_block  in  TAG_WIDTH / INDEX_WIDTH / BLOCK_WIDTH  fetch address fields
- i_hit  in  WAYS  per-way hit vector from the tag comparators (valid & tag match)
- i_flush  in  1  invalidate-all request
- i_mem_ack  in  1  memory word valid on the data bus this cycle
- o_mem_rd  out  1  memory read request
- o_tag / o_index / o_block  out  as inputs  array/memory address
- o_way  out  WAY_WIDTH  way written by o_wr, or the hit way in IDLE
- o_wr  out  1  write data word plus tag/valid into way o_way
- o_cl  out  1  clear valid bits of all ways at o_index
- o_hit  out  1  hit indication
- o_busy  out  1  controller not accepting fetches

## Operation
- State register, address latches (tag, index, block counter, victim) and per-set round-robin pointer array rr[SETS] of WAY_WIDTH bits. All outputs are combinational from state and inputs.
- Default outputs: o_tag/o_index/o_block follow i_*, o_way=0, o_wr=o_cl=o_mem_rd=o_hit=0, o_busy=1.
- INIT: o_cl=1, o_index=counter, rr[counter]<=0, counter+1. After counter=SETS-1, go to IDLE. Entered on reset or flush.
- IDLE: o_busy=0, o_hit=|i_hit, o_way=index of the lowest set bit of i_hit.
  - If i_flush: counter<=0 and go to INIT. Flush has priority over i_rd.
  - Else if i_rd & ~|i_hit: latch tag/index, block<=0, victim<=rr[i_index], go to FILL.
- FILL: o_mem_rd=1; o_tag/o_index/o_block = latched tag/index/block; o_way=victim; o_wr=i_mem_ack.
  - On ack, block+1 (wraps mod BLOCKS).
  - Ack with block=BLOCKS-1: rr[index]<=victim+1 mod WAYS, go to IDLE.
  - No ack: hold all values, wait indefinitely.
- i_flush is ignored outside IDLE; the requester holds it until o_busy=1 follows in IDLE. i_mem_ack is ignored outside FILL. i_rd and i_hit are ignored outside IDLE.
- Multiple bits set in i_hit is a tag-array error. The lowest way wins and there is no other effect.
- WAYS=1: o_way is always 0 and rr is constant 0, which gives direct-mapped behaviour.

## Timing
- Reset, cycle after i_reset is sampled high: state INIT, counter=0, o_cl=1, o_busy=1, o_index=0, o_wr=0, o_mem_rd=0, o_hit=0, o_way=0. Reset mid-FILL abandons the refill; the partially written line is cleared by INIT.
- INIT lasts exactly SETS cycles; o_busy falls in cycle SETS after reset.
- Hit: zero latency, same cycle as i_rd.
- Miss: FILL starts the next cycle. The refill takes a minimum of BLOCKS cycles with ack held high, plus 1 cycle to return to IDLE. Re-presenting the address then hits.
- Flush: INIT starts the cycle after i_flush is sampled in IDLE, and lasts SETS cycles.
- Exactly one o_wr per acked word; block words are written in order 0..BLOCKS-1.

## Test plan
- Reset, then idle: o_cl=1 with o_index 0..31 on consecutive cycles, then o_busy=0 at cycle 32; o_wr and o_mem_rd stay 0 throughout.
- Miss at tag=5, index=3, i_hit=00, ack held high: 4 cycles of o_mem_rd=1, o_wr=1, o_way=0, o_block 0,1,2,3. Back to IDLE; a second miss on index 3 uses o_way=1, and a third uses o_way=0 again.
- Ack stalls: ack pattern 1,0,0,1,1,0,1 yields exactly 4 o_wr pulses with o_block 0..3. Address is held stable during stall cycles; IDLE follows the last ack.
- Hit: i_rd=1, i_hit=10 in IDLE gives o_hit=1, o_way=1, o_busy=0 in the same cycle, with no state change. i_hit=11 gives o_way=0.
- i_flush=1 together with i_rd=1 and a miss in IDLE: INIT is entered, not FILL; 32 o_cl cycles follow; rr is reset, so the next miss uses way 0.
- i_reset asserted in FILL cycle 2: next cycle is INIT with o_cl=1, o_index=0, o_mem_rd=0.
